// File: rtl/store_buffer.sv
// store_buffer: in-order store queue between EX/MEM and the data memory.
// Stores are queued and drained one per cycle when the memory port is free.
// Loads are forwarded from the youngest fully-covering store, stalled on a
// partial overlap, and otherwise sent straight to memory.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_req_read,
  input  logic                   i_req_write,
  input  logic [ADDR_W-1:0]      i_req_addr,
  input  logic [DATA_W-1:0]      i_req_data,
  input  logic [2:0]             i_req_funct3,
  input  logic                   i_drain_en,
  output logic                   o_stall,
  output logic [DATA_W-1:0]      o_load_data,
  output logic                   o_load_hit,
  output logic [ADDR_W-1:0]      o_mem_addr,
  output logic [DATA_W-1:0]      o_mem_wdata,
  output logic                   o_mem_write,
  output logic                   o_mem_read,
  output logic [2:0]             o_mem_funct3,
  input  logic [DATA_W-1:0]      i_mem_rdata,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Byte size of a buffered store (only word and double are ever enqueued).
  function automatic logic [3:0] f_st_size(input logic [2:0] a_f3);
    return (a_f3 == 3'b011) ? 4'd8 : 4'd4;
  endfunction

  // Byte size of a load from the low funct3 bits (byte/half/word/double).
  function automatic logic [3:0] f_ld_size(input logic [2:0] a_f3);
    logic [3:0] v_size;
    case (a_f3[1:0])
      2'b00:   v_size = 4'd1;
      2'b01:   v_size = 4'd2;
      2'b10:   v_size = 4'd4;
      default: v_size = 4'd8;
    endcase
    return v_size;
  endfunction

  // True when byte ranges [a_ea, a_ea+a_es) and [a_ra, a_ra+a_rs) intersect.
  // One extra bit keeps the range ends from wrapping at the top of memory.
  function automatic logic f_overlap(input logic [ADDR_W-1:0] a_ea, input logic [3:0] a_es,
                                     input logic [ADDR_W-1:0] a_ra, input logic [3:0] a_rs);
    logic [ADDR_W:0] v_e_end;
    logic [ADDR_W:0] v_r_end;
    v_e_end = {1'b0, a_ea} + (ADDR_W+1)'(a_es);
    v_r_end = {1'b0, a_ra} + (ADDR_W+1)'(a_rs);
    return ({1'b0, a_ea} < v_r_end) && ({1'b0, a_ra} < v_e_end);
  endfunction

  // Entry storage; validity is tracked purely by head/count, so no reset.
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [2:0]        r_f3   [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [PTR_W-1:0]  w_idx;
  logic              w_found;
  logic              w_full_hit;
  logic [DATA_W-1:0] w_match_data;
  logic [DATA_W-1:0] w_hit_data;
  logic [3:0]        w_ld_size;
  logic              w_st_ok;
  logic              w_wr;
  logic              w_full;
  logic              w_empty;
  logic              w_ld_hit;
  logic              w_ld_part;
  logic              w_ld_miss;
  logic              w_drain;
  logic              w_push;

  assign w_ld_size = f_ld_size(i_req_funct3);
  assign w_st_ok   = (i_req_funct3 == 3'b010) || (i_req_funct3 == 3'b011);
  // A simultaneous read wins; the write half of an illegal request is dropped.
  assign w_wr      = i_req_write && !i_req_read && w_st_ok;
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == {CNT_W{1'b0}});

  // Scan entries oldest to youngest so the youngest overlapping entry decides.
  always_comb begin
    w_found      = 1'b0;
    w_full_hit   = 1'b0;
    w_match_data = {DATA_W{1'b0}};
    w_idx        = r_head;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PTR_W'(k);
      if ((CNT_W'(k) < r_count) &&
          f_overlap(r_addr[w_idx], f_st_size(r_f3[w_idx]), i_req_addr, w_ld_size)) begin
        w_found      = 1'b1;
        w_full_hit   = (r_addr[w_idx] == i_req_addr) && (f_st_size(r_f3[w_idx]) >= w_ld_size);
        w_match_data = r_data[w_idx];
      end else begin
        w_found      = w_found;
        w_full_hit   = w_full_hit;
        w_match_data = w_match_data;
      end
    end
  end

  // Trim forwarded data to the load width, zero-extended.
  always_comb begin
    w_hit_data = w_match_data;
    case (i_req_funct3[1:0])
      2'b00:   w_hit_data = w_match_data & DATA_W'(64'h0000_0000_0000_00FF);
      2'b01:   w_hit_data = w_match_data & DATA_W'(64'h0000_0000_0000_FFFF);
      2'b10:   w_hit_data = w_match_data & DATA_W'(64'h0000_0000_FFFF_FFFF);
      default: w_hit_data = w_match_data;
    endcase
  end

  // Reset is folded in so the outputs are quiet while reset_n is held low.
  assign w_ld_hit  = i_reset_n && i_req_read && w_found && w_full_hit;
  assign w_ld_part = i_reset_n && i_req_read && w_found && !w_full_hit;
  assign w_ld_miss = i_reset_n && i_req_read && !w_found;
  assign w_drain   = i_reset_n && !w_empty && i_drain_en && !w_ld_miss;
  assign w_push    = i_reset_n && w_wr && !w_full;

  assign o_stall      = i_reset_n && ((w_wr && w_full) || w_ld_part);
  assign o_load_hit   = w_ld_hit;
  assign o_mem_read   = w_ld_miss;
  assign o_mem_write  = w_drain;
  assign o_mem_addr   = w_ld_miss ? i_req_addr : r_addr[r_head];
  assign o_mem_funct3 = w_ld_miss ? i_req_funct3 : r_f3[r_head];
  assign o_mem_wdata  = r_data[r_head];
  assign o_empty      = w_empty;
  assign o_count      = r_count;

  // Select the load result: forwarded entry, memory data, or zero.
  always_comb begin
    o_load_data = {DATA_W{1'b0}};
    if (w_ld_hit) begin
      o_load_data = w_hit_data;
    end else if (w_ld_miss) begin
      o_load_data = i_mem_rdata;
    end else begin
      o_load_data = {DATA_W{1'b0}};
    end
  end

  // Queue pointers and occupancy; push and pop may happen in the same cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_drain) r_head <= r_head + PTR_W'(1);
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Capture the accepted store into the tail entry.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_addr[r_tail] <= i_req_addr;
      r_data[r_tail] <= i_req_data;
      r_f3[r_tail]   <= i_req_funct3;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed testbench for store_buffer with a small byte-addressed memory model.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_read, req_write, drain_en;
  logic [63:0] req_addr, req_data;
  logic [2:0]  req_funct3;
  logic        stall, load_hit, mem_write, mem_read, empty;
  logic [63:0] load_data, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_funct3;
  logic [2:0]  count;
  logic [7:0]  mem [0:255];
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .ADDR_W(64), .DATA_W(64)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_req_read(req_read), .i_req_write(req_write),
    .i_req_addr(req_addr), .i_req_data(req_data), .i_req_funct3(req_funct3),
    .i_drain_en(drain_en), .o_stall(stall), .o_load_data(load_data), .o_load_hit(load_hit),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_write(mem_write),
    .o_mem_read(mem_read), .o_mem_funct3(mem_funct3), .i_mem_rdata(mem_rdata),
    .o_empty(empty), .o_count(count)
  );

  // Combinational memory read: word zero-extended, double full width.
  always_comb begin
    mem_rdata = 64'd0;
    for (int k = 0; k < 8; k++) begin
      if (k < ((mem_funct3 == 3'b011) ? 8 : 4)) mem_rdata[8*k +: 8] = mem[8'(mem_addr[7:0] + 8'(k))];
    end
  end

  // Memory contents and write port.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'hEB; mem[1] = 8'h12; mem[2] = 8'h78; mem[3] = 8'h4F;
    mem[16] = 8'h35; mem[17] = 8'h3B; mem[18] = 8'h51; mem[19] = 8'h5F;
    forever begin
      @(posedge clk);
      if (mem_write) begin
        for (int k = 0; k < ((mem_funct3 == 3'b011) ? 8 : 4); k++) mem[8'(mem_addr[7:0] + 8'(k))] = mem_wdata[8*k +: 8];
      end
    end
  end

  task automatic set_req(input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] d, input logic [2:0] f3);
    req_read = rd; req_write = wr; req_addr = a; req_data = d; req_funct3 = f3;
  endtask

  task automatic test_reset;
    drain_en = 1'b1;
    set_req(1'b1, 1'b0, 64'd0, 64'd0, 3'b010);
    #1 reset_n = 1'b0;
    #1;
    n_total++; if (empty !== 1'b1) $display("FAIL rst_empty: got %0h want 1", empty); else n_pass++;
    n_total++; if (count !== 3'd0) $display("FAIL rst_count: got %0d want 0", count); else n_pass++;
    n_total++; if (stall !== 1'b0) $display("FAIL rst_stall: got %0h want 0", stall); else n_pass++;
    n_total++; if (mem_write !== 1'b0) $display("FAIL rst_mem_write: got %0h want 0", mem_write); else n_pass++;
    n_total++; if (mem_read !== 1'b0) $display("FAIL rst_mem_read: got %0h want 0", mem_read); else n_pass++;
    n_total++; if (load_hit !== 1'b0) $display("FAIL rst_load_hit: got %0h want 0", load_hit); else n_pass++;
    n_total++; if (load_data !== 64'd0) $display("FAIL rst_load_data: got %h want 0", load_data); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    set_req(1'b0, 1'b0, 64'd0, 64'd0, 3'b010);
  endtask

  task automatic test_miss;
    @(negedge clk); set_req(1'b1, 1'b0, 64'd0, 64'd0, 3'b010); #1;
    n_total++; if (mem_read !== 1'b1) $display("FAIL miss_mem_read: got %0h want 1", mem_read); else n_pass++;
    n_total++; if (load_hit !== 1'b0) $display("FAIL miss_hit: got %0h want 0", load_hit); else n_pass++;
    n_total++; if (load_data !== 64'h00000000_4F7812EB) $display("FAIL miss_data: got %h want 000000004f7812eb", load_data); else n_pass++;
    n_total++; if (mem_addr !== 64'd0) $display("FAIL miss_addr: got %h want 0", mem_addr); else n_pass++;
  endtask

  task automatic test_forward;
    drain_en = 1'b1;
    @(negedge clk); set_req(1'b0, 1'b1, 64'd8, 64'h11223344_55667788, 3'b011); #1;
    n_total++; if (mem_write !== 1'b0) $display("FAIL fwd_no_early_write: got %0h want 0", mem_write); else n_pass++;
    @(negedge clk); set_req(1'b1, 1'b0, 64'd8, 64'd0, 3'b011); #1;
    n_total++; if (load_hit !== 1'b1) $display("FAIL fwd_hit: got %0h want 1", load_hit); else n_pass++;
    n_total++; if (load_data !== 64'h11223344_55667788) $display("FAIL fwd_data: got %h want 1122334455667788", load_data); else n_pass++;
    n_total++; if (mem_read !== 1'b0) $display("FAIL fwd_mem_read: got %0h want 0", mem_read); else n_pass++;
    n_total++; if (mem_write !== 1'b1) $display("FAIL fwd_mem_write: got %0h want 1", mem_write); else n_pass++;
    n_total++; if (mem_addr !== 64'd8) $display("FAIL fwd_mem_addr: got %h want 8", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 64'h11223344_55667788) $display("FAIL fwd_mem_wdata: got %h want 1122334455667788", mem_wdata); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (count !== 3'd0) $display("FAIL fwd_drained_count: got %0d want 0", count); else n_pass++;
    n_total++; if (load_hit !== 1'b0) $display("FAIL fwd_after_hit: got %0h want 0", load_hit); else n_pass++;
    n_total++; if (load_data !== 64'h11223344_55667788) $display("FAIL fwd_mem_data: got %h want 1122334455667788", load_data); else n_pass++;
  endtask

  task automatic test_partial;
    drain_en = 1'b0;
    @(negedge clk); set_req(1'b0, 1'b1, 64'd4, 64'h00000000_DEADBEEF, 3'b010);
    @(negedge clk); set_req(1'b1, 1'b0, 64'd0, 64'd0, 3'b011); #1;
    n_total++; if (stall !== 1'b1) $display("FAIL part_stall: got %0h want 1", stall); else n_pass++;
    n_total++; if (mem_read !== 1'b0) $display("FAIL part_mem_read: got %0h want 0", mem_read); else n_pass++;
    n_total++; if (mem_write !== 1'b0) $display("FAIL part_blocked_write: got %0h want 0", mem_write); else n_pass++;
    @(negedge clk); drain_en = 1'b1; #1;
    n_total++; if (stall !== 1'b1) $display("FAIL part_stall_drain: got %0h want 1", stall); else n_pass++;
    n_total++; if (mem_write !== 1'b1 || mem_addr !== 64'd4) $display("FAIL part_drain: got write=%0h addr=%h want write=1 addr=4", mem_write, mem_addr); else n_pass++;
    @(negedge clk); drain_en = 1'b0; #1;
    n_total++; if (stall !== 1'b0) $display("FAIL part_release: got %0h want 0", stall); else n_pass++;
    n_total++; if (load_data !== 64'hDEADBEEF_4F7812EB) $display("FAIL part_data: got %h want deadbeef4f7812eb", load_data); else n_pass++;
    n_total++; if (mem_read !== 1'b1) $display("FAIL part_mem_read2: got %0h want 1", mem_read); else n_pass++;
  endtask

  task automatic test_noop;
    @(negedge clk); set_req(1'b0, 1'b1, 64'd0, 64'h99, 3'b000); #1;
    n_total++; if (stall !== 1'b0) $display("FAIL noop_stall: got %0h want 0", stall); else n_pass++;
    @(negedge clk); set_req(1'b1, 1'b1, 64'd0, 64'h99, 3'b010); #1;
    n_total++; if (count !== 3'd0) $display("FAIL noop_count: got %0d want 0", count); else n_pass++;
    n_total++; if (mem_read !== 1'b1 || load_data !== 64'h00000000_4F7812EB) $display("FAIL rdwr_read: got rd=%0h data=%h want rd=1 data=000000004f7812eb", mem_read, load_data); else n_pass++;
    @(negedge clk); set_req(1'b0, 1'b0, 64'd0, 64'd0, 3'b010); #1;
    n_total++; if (empty !== 1'b1) $display("FAIL rdwr_empty: got %0h want 1", empty); else n_pass++;
  endtask

  task automatic test_width;
    drain_en = 1'b0;
    @(negedge clk); set_req(1'b0, 1'b1, 64'd40, 64'hCAFEF00D_01234567, 3'b011);
    @(negedge clk); set_req(1'b1, 1'b0, 64'd40, 64'd0, 3'b010); #1;
    n_total++; if (load_hit !== 1'b1 || load_data !== 64'h00000000_01234567) $display("FAIL width_lw_hit: got hit=%0h data=%h want hit=1 data=0000000001234567", load_hit, load_data); else n_pass++;
    @(negedge clk); set_req(1'b1, 1'b0, 64'd44, 64'd0, 3'b010); #1;
    n_total++; if (stall !== 1'b1) $display("FAIL width_offset_stall: got %0h want 1", stall); else n_pass++;
    @(negedge clk); set_req(1'b0, 1'b1, 64'd48, 64'h55, 3'b010);
    @(negedge clk); set_req(1'b1, 1'b0, 64'd48, 64'd0, 3'b011); #1;
    n_total++; if (stall !== 1'b1 || load_hit !== 1'b0) $display("FAIL width_narrow_stall: got stall=%0h hit=%0h want stall=1 hit=0", stall, load_hit); else n_pass++;
    @(negedge clk); drain_en = 1'b1; set_req(1'b1, 1'b0, 64'd52, 64'd0, 3'b010); #1;
    n_total++; if (mem_read !== 1'b1 || mem_addr !== 64'd52) $display("FAIL width_miss: got rd=%0h addr=%h want rd=1 addr=34", mem_read, mem_addr); else n_pass++;
    n_total++; if (mem_write !== 1'b0) $display("FAIL width_port_busy: got %0h want 0", mem_write); else n_pass++;
    @(negedge clk); set_req(1'b0, 1'b0, 64'd0, 64'd0, 3'b010); #1;
    n_total++; if (count !== 3'd2) $display("FAIL width_count: got %0d want 2", count); else n_pass++;
    @(negedge clk);
    @(negedge clk); drain_en = 1'b0; #1;
    n_total++; if (empty !== 1'b1) $display("FAIL width_empty: got %0h want 1", empty); else n_pass++;
  endtask

  task automatic test_full;
    logic [63:0] exp_addr, exp_data;
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); set_req(1'b0, 1'b1, 64'(64 + 4*i), 64'(32'h1000 + i), 3'b010); #1;
      n_total++; if (stall !== 1'b0) $display("FAIL full_fill_stall%0d: got %0h want 0", i, stall); else n_pass++;
    end
    @(negedge clk); set_req(1'b0, 1'b1, 64'd80, 64'h55555555, 3'b010); #1;
    n_total++; if (count !== 3'd4 || stall !== 1'b1) $display("FAIL full_stall: got count=%0d stall=%0h want count=4 stall=1", count, stall); else n_pass++;
    @(negedge clk); drain_en = 1'b1; #1;
    n_total++; if (stall !== 1'b1 || count !== 3'd4) $display("FAIL full_pop_stall: got stall=%0h count=%0d want stall=1 count=4", stall, count); else n_pass++;
    n_total++; if (mem_write !== 1'b1 || mem_addr !== 64'd64) $display("FAIL full_head: got write=%0h addr=%h want write=1 addr=40", mem_write, mem_addr); else n_pass++;
    @(negedge clk); drain_en = 1'b0; #1;
    n_total++; if (count !== 3'd3 || stall !== 1'b0) $display("FAIL full_accept: got count=%0d stall=%0h want count=3 stall=0", count, stall); else n_pass++;
    @(negedge clk); set_req(1'b0, 1'b0, 64'd0, 64'd0, 3'b010); #1;
    n_total++; if (count !== 3'd4) $display("FAIL full_refill: got %0d want 4", count); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin exp_addr = 64'd80; exp_data = 64'h55555555; end
      else begin exp_addr = 64'(68 + 4*i); exp_data = 64'(32'h1001 + i); end
      @(negedge clk); drain_en = 1'b1; #1;
      n_total++; if (mem_write !== 1'b1 || mem_addr !== exp_addr || mem_wdata !== exp_data) $display("FAIL full_order%0d: got addr=%h data=%h want addr=%h data=%h", i, mem_addr, mem_wdata, exp_addr, exp_data); else n_pass++;
    end
    @(negedge clk); drain_en = 1'b0; #1;
    n_total++; if (empty !== 1'b1) $display("FAIL full_empty: got %0h want 1", empty); else n_pass++;
  endtask

  task automatic test_youngest;
    drain_en = 1'b0;
    @(negedge clk); set_req(1'b0, 1'b1, 64'd32, 64'hAAAA0001, 3'b010);
    @(negedge clk); set_req(1'b0, 1'b1, 64'd32, 64'hBBBB0002, 3'b010);
    @(negedge clk); set_req(1'b1, 1'b0, 64'd32, 64'd0, 3'b010); #1;
    n_total++; if (load_hit !== 1'b1 || load_data !== 64'h00000000_BBBB0002) $display("FAIL young_hit: got hit=%0h data=%h want hit=1 data=00000000bbbb0002", load_hit, load_data); else n_pass++;
    n_total++; if (count !== 3'd2) $display("FAIL young_count: got %0d want 2", count); else n_pass++;
    @(negedge clk); set_req(1'b0, 1'b1, 64'd34, 64'h77, 3'b010);
    @(negedge clk); set_req(1'b1, 1'b0, 64'd32, 64'd0, 3'b010); #1;
    n_total++; if (stall !== 1'b1 || load_hit !== 1'b0) $display("FAIL young_mask: got stall=%0h hit=%0h want stall=1 hit=0", stall, load_hit); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drain_en = 1'b1; set_req(1'b0, 1'b0, 64'd0, 64'd0, 3'b010);
    end
    @(negedge clk); drain_en = 1'b0; set_req(1'b1, 1'b0, 64'd32, 64'd0, 3'b010); #1;
    n_total++; if (empty !== 1'b1) $display("FAIL young_empty: got %0h want 1", empty); else n_pass++;
    n_total++; if (load_data !== 64'h00000000_00770002) $display("FAIL young_mem: got %h want 0000000000770002", load_data); else n_pass++;
  endtask

  task automatic test_reset_mid;
    drain_en = 1'b0;
    @(negedge clk); set_req(1'b0, 1'b1, 64'd16, 64'h12345678, 3'b010);
    @(negedge clk); set_req(1'b0, 1'b1, 64'd20, 64'h9ABCDEF0, 3'b010);
    @(negedge clk); set_req(1'b0, 1'b0, 64'd0, 64'd0, 3'b010); drain_en = 1'b1; #1;
    n_total++; if (count !== 3'd2 || mem_write !== 1'b1) $display("FAIL mid_pre: got count=%0d write=%0h want count=2 write=1", count, mem_write); else n_pass++;
    #1 reset_n = 1'b0;
    #1;
    n_total++; if (count !== 3'd0 || empty !== 1'b1) $display("FAIL mid_cleared: got count=%0d empty=%0h want count=0 empty=1", count, empty); else n_pass++;
    n_total++; if (mem_write !== 1'b0) $display("FAIL mid_mem_write: got %0h want 0", mem_write); else n_pass++;
    @(negedge clk); reset_n = 1'b1; drain_en = 1'b0; set_req(1'b1, 1'b0, 64'd16, 64'd0, 3'b010); #1;
    n_total++; if (load_data !== 64'h00000000_5F513B35 || load_hit !== 1'b0) $display("FAIL mid_mem: got data=%h hit=%0h want data=000000005f513b35 hit=0", load_data, load_hit); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_miss();
    test_forward();
    test_partial();
    test_noop();
    test_width();
    test_full();
    test_youngest();
    test_reset_mid();
    @(negedge clk); set_req(1'b0, 1'b0, 64'd0, 64'd0, 3'b010);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits between the EX/MEM pipeline register and the data memory in the pipelined processor.
- Queues stores (sw/sd) in a FIFO and drains one store per cycle to the byte-addressed data memory when the memory port is free.
- Loads go to memory directly, or are forwarded from a buffered store when the addresses match.
- Raises `stall` to the hazard unit when the buffer is full or a load partially overlaps a buffered store.

Parameters:
DEPTH, 4, number of store entries (power of 2, >=2)
ADDR_W, 64, address width
DATA_W, 64, data width

Ports:
clk  in  1  clock, all state updates on posedge
reset_n  in  1  asynchronous active-low reset
req_read  in  1  load request from EX/MEM
req_write  in  1  store request from EX/MEM
req_addr  in  ADDR_W  byte address
req_data  in  DATA_W  store data
req_funct3  in  3  010 = word, 011 = double
drain_en  in  1  memory-port grant from arbiter; 0 blocks draining
stall  out  1  freeze the upstream pipeline this cycle
load_data  out  DATA_W  load result to MEM/WB
load_hit  out  1  load_data was forwarded from the buffer
mem_addr  out  ADDR_W  to data memory
mem_wdata  out  DATA_W  to data memory
mem_write  out  1  to data memory
mem_read  out  1  to data memory
mem_funct3  out  3  to data memory
mem_rdata  in  DATA_W  combinational read data from data memory
empty  out  1  no valid entries
count  out  $clog2(DEPTH)+1  valid entries

Behaviour:
- **Reset:** asynchronous, reset_n low clears head, tail and count to 0.
  - Outputs held: empty=1, stall=0, mem_write=0, mem_read=0, load_hit=0, load_data=0.
  - Pending stores are discarded; reset mid-drain leaves memory holding only stores already written on earlier edges.
- **Entry format:** {addr, data, funct3}. Size is 4 bytes for 010, 8 bytes for 011. Stores with any other funct3 are neither enqueued nor stalled (no-op).
- **Request encoding:** req_read and req_write both high is illegal; read takes precedence.
- **Load match:** all valid entries are compared; the youngest matching entry wins.
  - Full hit: entry addr == req_addr and entry size >= load size.
    - load_hit=1.
    - Word load returns {32'b0, entry_data[31:0]}; double load returns entry_data.
    - mem_read=0.
  - Partial overlap: byte ranges intersect but not a full hit, including a younger overlapping non-hit masking an older hit.
    - stall=1, mem_read=0.
    - The head keeps draining (if drain_en) until no overlap remains.
  - Miss: mem_read=1, mem_addr=req_addr, mem_funct3=req_funct3, load_data=mem_rdata, load_hit=0.
- **All load outputs are combinational:** zero-cycle latency, same as the data memory.
- **Drain:**
  - Condition: !empty && drain_en && memory port not used by a miss load this cycle.
  - When the condition holds: mem_write=1 and mem_addr/mem_wdata/mem_funct3 are taken from the head entry. The memory writes and the head pops on the same posedge.
  - Otherwise mem_write=0.
- **Push:** req_write with a valid funct3 and count<DEPTH enqueues at the tail on posedge.
  - If count==DEPTH, stall=1 and no push, even if a pop occurs that cycle; the store is accepted the following cycle.
- **Count:** simultaneous push+pop leaves count unchanged; pointers wrap modulo DEPTH.
- **Latency:** a store accepted at edge N is written to memory at edge N+1 at the earliest.
- **Ordering:** stores drain strictly in program order.
- **stall:** combinational: (req_write && full) || (req_read && partial overlap).

Test Plan:
- Reset, lw addr 0 → mem_read=1, load_hit=0, load_data=0x00000000_4F7812EB.
- sd addr 8 data 0x1122334455667788, next cycle ld addr 8 → load_hit=1, load_data=0x1122334455667788; same cycle mem_write=1, mem_addr=8 (drain proceeds because the port is free).
- drain_en=0, sw addr 4 data 0xDEADBEEF, then ld addr 0:
  - Stall phase: stall=1.
  - Release: raise drain_en → next cycle stall=0, load_data=0xDEADBEEF_4F7812EB from memory.
- drain_en=0, five consecutive sw → count reaches 4; 5th cycle stall=1 and count stays 4; drain_en=1 → 5th store accepted one cycle later, count returns to 4.
- drain_en=0, sw 32 0xAAAA0001 then sw 32 0xBBBB0002, lw 32 → load_hit=1, load_data=0x00000000_BBBB0002.
- drain_en=0, sw 16 0x12345678, sw 20 0x9ABCDEF0; pull reset_n low mid-cycle → count=0, empty=1, mem_write=0 immediately; after release, lw 16 → 0x00000000_5F513B35 (memory unchanged).
